// File: rtl/hps_sd_sector_bridge.sv
// Sector bridge between the HPS virtual-disk handshake and one SCSI target.
// Holds one 512-byte buffer, bounds-checks requests, times out stalled ones.
module hps_sd_sector_bridge #(
   parameter logic [26:0] TIMEOUT = 27'd65000000,
   parameter int          LBA_W   = 32
) (
   input  logic             clk_sys,
   input  logic             reset_n,
   input  logic             img_mounted,
   input  logic [63:0]      img_size,
   input  logic             img_readonly,
   output logic [LBA_W-1:0] sd_lba,
   output logic             sd_rd,
   output logic             sd_wr,
   input  logic             sd_ack,
   input  logic [7:0]       sd_buff_addr,
   input  logic [15:0]      sd_buff_dout,
   input  logic             sd_buff_wr,
   output logic [15:0]      sd_buff_din,
   input  logic             req_rd,
   input  logic             req_wr,
   input  logic [LBA_W-1:0] req_lba,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic             mounted,
   output logic [LBA_W-1:0] nsectors,
   output logic             wprot,
   input  logic [8:0]       buf_addr,
   input  logic [7:0]       buf_wdata,
   input  logic             buf_we,
   output logic [7:0]       buf_rdata
);

   typedef enum logic [1:0] {IDLE, REQ, XFER, FINISH} state_t;

   state_t      state, state_nx;
   logic        dir_wr;
   logic        bnd_err;
   logic [26:0] cnt;
   logic        is_wr, bad;
   logic        accept, reject, fail;
   logic        hps_we, core_we;

   logic [7:0] ram_lo [256];
   logic [7:0] ram_hi [256];

   assign is_wr = req_wr && !req_rd;
   assign bad   = !mounted || (req_lba >= nsectors) || (is_wr && wprot);

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      accept   = 1'b0;
      reject   = 1'b0;
      fail     = 1'b0;
      unique case (state)
         IDLE: begin
            if (req_rd || req_wr) begin
               if (bad) begin
                  state_nx = FINISH;
                  reject   = 1'b1;
               end else begin
                  state_nx = REQ;
                  accept   = 1'b1;
               end
            end
         end
         REQ: begin
            if (img_mounted) begin
               state_nx = FINISH;
               fail     = 1'b1;
            end else if (sd_ack) begin
               state_nx = XFER;
            end else if (TIMEOUT != 27'd0 && cnt == TIMEOUT - 27'd1) begin
               state_nx = FINISH;
               fail     = 1'b1;
            end
         end
         XFER: begin
            if (img_mounted) begin
               state_nx = FINISH;
               fail     = 1'b1;
            end else if (!sd_ack) begin
               state_nx = FINISH;
            end
         end
         FINISH: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      sd_rd = (state == REQ) && !dir_wr;
      sd_wr = (state == REQ) && dir_wr;
      done  = (state == FINISH);
      busy  = (state == REQ) || (state == XFER) ||
              ((state == FINISH) && bnd_err);
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sd_lba   <= '0;
         dir_wr   <= 1'b0;
         bnd_err  <= 1'b0;
         err      <= 1'b0;
         cnt      <= '0;
         mounted  <= 1'b0;
         nsectors <= '0;
         wprot    <= 1'b0;
      end else begin
         if (accept) begin
            sd_lba  <= req_lba;
            dir_wr  <= is_wr;
            bnd_err <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
         end else if (state == REQ && cnt != '1) begin
            cnt <= cnt + 27'd1;
         end
         if (reject) begin
            bnd_err <= 1'b1;
            err     <= 1'b1;
         end
         if (fail) err <= 1'b1;
         if (img_mounted) begin
            nsectors <= img_size[LBA_W+8:9];
            mounted  <= (img_size >= 64'd512);
            wprot    <= img_readonly;
         end
      end
   end

   // HPS fills the buffer only during an active read transfer
   assign hps_we  = sd_buff_wr && sd_ack && !dir_wr &&
                    ((state == REQ) || (state == XFER));
   assign core_we = buf_we && !busy;

   always_ff @(posedge clk_sys) begin
      if (hps_we) begin
         ram_lo[sd_buff_addr] <= sd_buff_dout[7:0];
         ram_hi[sd_buff_addr] <= sd_buff_dout[15:8];
      end
      if (core_we && !buf_addr[0]) ram_lo[buf_addr[8:1]] <= buf_wdata;
      if (core_we && buf_addr[0])  ram_hi[buf_addr[8:1]] <= buf_wdata;
      buf_rdata   <= buf_addr[0] ? ram_hi[buf_addr[8:1]]
                                 : ram_lo[buf_addr[8:1]];
      sd_buff_din <= {ram_hi[sd_buff_addr], ram_lo[sd_buff_addr]};
   end

endmodule

// File: tb/tb_hps_sd_sector_bridge.sv
// Directed bench for hps_sd_sector_bridge (TIMEOUT shortened to 100).
module tb_hps_sd_sector_bridge;

   logic        clk_sys = 1'b0;
   logic        reset_n;
   logic        img_mounted;
   logic [63:0] img_size;
   logic        img_readonly;
   logic [31:0] sd_lba;
   logic        sd_rd, sd_wr, sd_ack;
   logic [7:0]  sd_buff_addr;
   logic [15:0] sd_buff_dout;
   logic        sd_buff_wr;
   logic [15:0] sd_buff_din;
   logic        req_rd, req_wr;
   logic [31:0] req_lba;
   logic        busy, done, err, mounted, wprot;
   logic [31:0] nsectors;
   logic [8:0]  buf_addr;
   logic [7:0]  buf_wdata;
   logic        buf_we;
   logic [7:0]  buf_rdata;

   int checks = 0;
   int errors = 0;

   hps_sd_sector_bridge #(.TIMEOUT(27'd100), .LBA_W(32)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n),
      .img_mounted(img_mounted), .img_size(img_size),
      .img_readonly(img_readonly),
      .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
      .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din),
      .req_rd(req_rd), .req_wr(req_wr), .req_lba(req_lba),
      .busy(busy), .done(done), .err(err), .mounted(mounted),
      .nsectors(nsectors), .wprot(wprot),
      .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_we(buf_we),
      .buf_rdata(buf_rdata)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic tick;
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic mount(input logic [63:0] size, input logic ro);
      img_mounted  = 1'b1;
      img_size     = size;
      img_readonly = ro;
      tick;
      img_mounted  = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0; img_mounted = 1'b0; img_size = '0; img_readonly = 1'b0;
      sd_ack = 1'b0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
      req_rd = 1'b0; req_wr = 1'b0; req_lba = '0;
      buf_addr = '0; buf_wdata = '0; buf_we = 1'b0;
      tick; tick;
      chk("rst_sd_rd", sd_rd, 0);
      chk("rst_sd_wr", sd_wr, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_mounted", mounted, 0);
      chk("rst_nsectors", nsectors, 0);
      chk("rst_sd_lba", sd_lba, 0);
      reset_n = 1'b1;
      tick;

      // mount and HPS read of sector 5
      mount(64'd1048576, 1'b0);
      chk("mnt_mounted", mounted, 1);
      chk("mnt_nsectors", nsectors, 2048);
      chk("mnt_wprot", wprot, 0);
      req_rd = 1'b1; req_lba = 32'd5;
      tick;
      req_rd = 1'b0;
      chk("rd_sd_rd", sd_rd, 1);
      chk("rd_sd_lba", sd_lba, 5);
      chk("rd_busy", busy, 1);
      sd_ack = 1'b1;
      tick;
      chk("rd_drop", sd_rd, 0);
      for (int k = 0; k < 256; k++) begin
         sd_buff_addr = 8'(k);
         sd_buff_dout = 16'(k * 16'h0101);
         sd_buff_wr   = 1'b1;
         tick;
      end
      sd_buff_wr = 1'b0;
      sd_ack = 1'b0;
      tick;
      chk("rd_done", done, 1);
      chk("rd_err", err, 0);
      chk("rd_busy_fin", busy, 0);
      tick;
      chk("rd_done_once", done, 0);
      buf_addr = 9'h1FF;
      tick;
      chk("rd_byte_1ff", buf_rdata, 8'hFF);
      buf_addr = 9'h021;
      tick;
      chk("rd_byte_021", buf_rdata, 8'h10);

      // core fill, then HPS write of sector 2047
      for (int i = 0; i < 512; i++) begin
         buf_we = 1'b1; buf_addr = 9'(i); buf_wdata = 8'(i);
         tick;
      end
      buf_we = 1'b0;
      buf_addr = 9'h0FE;
      tick;
      chk("core_byte_0fe", buf_rdata, 8'hFE);
      sd_ack = 1'b1; sd_buff_wr = 1'b1;
      sd_buff_addr = 8'h7F; sd_buff_dout = 16'hBEEF;
      tick;
      sd_ack = 1'b0; sd_buff_wr = 1'b0;
      chk("idle_spur_busy", busy, 0);
      tick;
      chk("idle_spur_buf", buf_rdata, 8'hFE);
      req_wr = 1'b1; req_lba = 32'd2047;
      tick;
      req_wr = 1'b0;
      chk("wr_sd_wr", sd_wr, 1);
      chk("wr_sd_rd", sd_rd, 0);
      chk("wr_sd_lba", sd_lba, 2047);
      sd_ack = 1'b1; sd_buff_addr = 8'h10;
      tick;
      chk("wr_din_10", sd_buff_din, 16'h2120);
      sd_buff_wr = 1'b1; sd_buff_dout = 16'hDEAD;
      tick;
      sd_buff_wr = 1'b0;
      tick;
      chk("wr_no_hps_write", sd_buff_din, 16'h2120);
      sd_ack = 1'b0;
      tick;
      chk("wr_done", done, 1);
      chk("wr_err", err, 0);
      tick;

      // bounds, write-protect and unmounted errors
      req_rd = 1'b1; req_lba = 32'd2048;
      tick;
      req_rd = 1'b0;
      chk("oob_sd_rd", sd_rd, 0);
      chk("oob_done", done, 1);
      chk("oob_err", err, 1);
      chk("oob_busy", busy, 1);
      tick;
      chk("oob_done_off", done, 0);
      chk("oob_err_hold", err, 1);
      mount(64'd1048576, 1'b1);
      chk("wp_wprot", wprot, 1);
      req_wr = 1'b1; req_lba = 32'd0;
      tick;
      req_wr = 1'b0;
      chk("wp_sd_wr", sd_wr, 0);
      chk("wp_done", done, 1);
      chk("wp_err", err, 1);
      tick;
      mount(64'd100, 1'b0);
      chk("um_mounted", mounted, 0);
      req_rd = 1'b1; req_lba = 32'd0;
      tick;
      req_rd = 1'b0;
      chk("um_sd_rd", sd_rd, 0);
      chk("um_done", done, 1);
      chk("um_err", err, 1);
      tick;
      mount(64'd1048576, 1'b0);

      // timeout after 100 cycles in REQ
      req_rd = 1'b1; req_lba = 32'd1;
      tick;
      req_rd = 1'b0;
      chk("to_sd_rd", sd_rd, 1);
      chk("to_err_clr", err, 0);
      for (int i = 0; i < 99; i++) tick;
      chk("to_still_req", sd_rd, 1);
      chk("to_not_done", done, 0);
      tick;
      chk("to_sd_rd_drop", sd_rd, 0);
      chk("to_done", done, 1);
      chk("to_err", err, 1);
      tick;

      // priority, ignored requests, ignored core write
      req_rd = 1'b1; req_wr = 1'b1; req_lba = 32'd3;
      tick;
      req_wr = 1'b0; req_lba = 32'd7;
      chk("pri_sd_rd", sd_rd, 1);
      chk("pri_sd_wr", sd_wr, 0);
      tick;
      req_rd = 1'b0;
      chk("ign_lba", sd_lba, 3);
      sd_ack = 1'b1;
      tick;
      req_rd = 1'b1;
      buf_we = 1'b1; buf_addr = 9'h1FF; buf_wdata = 8'h00;
      tick;
      req_rd = 1'b0; buf_we = 1'b0;
      chk("ign_xfer_sd_rd", sd_rd, 0);
      sd_ack = 1'b0;
      tick;
      chk("pri_done", done, 1);
      chk("pri_err", err, 0);
      tick;
      chk("pri_single_done", done, 0);
      chk("pri_idle_busy", busy, 0);
      tick;
      chk("busy_we_ignored", buf_rdata, 8'hFF);

      // asynchronous reset mid-transfer
      req_rd = 1'b1; req_lba = 32'd4;
      tick;
      req_rd = 1'b0;
      sd_ack = 1'b1;
      tick;
      chk("ar_busy_before", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("ar_busy", busy, 0);
      chk("ar_sd_rd", sd_rd, 0);
      chk("ar_done", done, 0);
      chk("ar_err", err, 0);
      chk("ar_mounted", mounted, 0);
      sd_ack = 1'b0;
      tick;
      reset_n = 1'b1;
      tick;
      mount(64'd1048576, 1'b0);
      req_rd = 1'b1; req_lba = 32'd9;
      tick;
      req_rd = 1'b0;
      chk("ar2_sd_rd", sd_rd, 1);
      chk("ar2_lba", sd_lba, 9);
      sd_ack = 1'b1;
      tick;
      sd_ack = 1'b0;
      tick;
      chk("ar2_done", done, 1);
      chk("ar2_err", err, 0);
      tick;

      // remount during REQ aborts the transfer
      req_rd = 1'b1; req_lba = 32'd6;
      tick;
      req_rd = 1'b0;
      chk("rm_sd_rd", sd_rd, 1);
      mount(64'd1048576, 1'b0);
      chk("rm_done", done, 1);
      chk("rm_err", err, 1);
      chk("rm_sd_rd_drop", sd_rd, 0);
      tick;
      chk("rm_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hps_sd_sector_bridge.md
Name: hps_sd_sector_bridge

Overview:
- Sits between the HPS I/O virtual-disk interface (sd_lba/sd_rd/sd_wr/sd_ack/sd_buff_*) and one SCSI target inside the SparcStation core. One instance per virtual disk (HD, HD2, CDROM).
- Holds one 512-byte sector buffer.
- Converts a simple core-side sector read/write request into the HPS handshake. Provides bounds checking against image size and a timeout.

Parameters:
TIMEOUT, 27'd65000000, clk_sys cycles allowed from request to first sd_ack rise (1 s at 65 MHz); 0 disables the timeout.
LBA_W, 32, width of sector address.

Ports:
clk_sys  in  1  system clock
reset_n  in  1  asynchronous active-low reset
img_mounted  in  1  one-cycle pulse when an image is (re)mounted or unmounted
img_size  in  64  image size in bytes, valid when img_mounted pulses
img_readonly  in  1  image write-protected, sampled with img_mounted
sd_lba  out  LBA_W  sector address presented to HPS
sd_rd  out  1  HPS read request
sd_wr  out  1  HPS write request
sd_ack  in  1  HPS transfer in progress
sd_buff_addr  in  8  HPS word address (0..255)
sd_buff_dout  in  16  HPS write data into buffer (read direction)
sd_buff_wr  in  1  HPS buffer write strobe
sd_buff_din  out  16  buffer data to HPS (write direction)
req_rd  in  1  core: start sector read (one-cycle pulse)
req_wr  in  1  core: start sector write (one-cycle pulse)
req_lba  in  LBA_W  core: sector number, sampled with req_*
busy  out  1  transfer in progress
done  out  1  one-cycle pulse at end of transfer (success or error)
err  out  1  status of last transfer, valid from done until next request
mounted  out  1  image present (size >= 512)
nsectors  out  LBA_W  image size in sectors (img_size[LBA_W+8:9])
wprot  out  1  latched img_readonly
buf_addr  in  9  core byte address into sector buffer
buf_wdata  in  8  core write byte
buf_we  in  1  core byte write strobe
buf_rdata  out  8  core read byte, 1-cycle latency

Behaviour:
- Reset (async, reset_n=0): state IDLE. sd_rd=0, sd_wr=0, sd_lba=0, busy=0, done=0, err=0, mounted=0, nsectors=0, wprot=0, timeout counter=0. Buffer contents are undefined. buf_rdata and sd_buff_din are undefined until the first clock.
- Mount tracking: on img_mounted=1, latch nsectors=img_size>>9, set mounted=(img_size>=512), and latch wprot=img_readonly.
  - If img_mounted pulses while busy, the current transfer completes as an error in the next cycle: done=1, err=1, sd_rd/sd_wr dropped.
- Buffer: 256x16 true dual-port RAM.
  - Byte 2n is word n [7:0]; byte 2n+1 is word n [15:8] (little-endian).
  - Core port: buf_we writes one byte lane. buf_rdata is registered, so it is valid the cycle after buf_addr.
  - Core writes while busy=1 are ignored. Core reads are always allowed.
  - HPS port: sd_buff_wr writes word sd_buff_addr, but only when sd_ack=1 and the transfer is a read. sd_buff_din is registered: data of word sd_buff_addr, one cycle later.
- State machine:
  - IDLE: req_rd has priority over req_wr if both pulse in the same cycle. On either request:
    - If mounted=0, or req_lba>=nsectors, or (req_wr and wprot): go to FINISH with err=1. No HPS request is issued.
    - Otherwise latch sd_lba=req_lba, assert sd_rd or sd_wr, set busy=1, clear timeout counter, go to REQ.
  - REQ: hold sd_rd/sd_wr. On sd_ack=1: drop sd_rd/sd_wr, go to XFER. If the counter reaches TIMEOUT-1 (TIMEOUT!=0): drop the request and go to FINISH with err=1.
  - XFER: the HPS moves words. On sd_ack falling (1->0): go to FINISH with err=0.
  - FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. err holds until the next accepted request, which clears it.
- busy is 1 in REQ and XFER, and in the FINISH cycle of a bounds error.
- Requests arriving while not IDLE are ignored: no queueing.
- Latency: request to sd_rd/sd_wr high is 1 cycle. sd_ack fall to done is 1 cycle. Bounds error: done follows the request by 1 cycle.
- Spurious sd_ack or sd_buff_wr while IDLE: no effect on state or buffer.
- Timeout counter: 27 bits, saturating, counts only in REQ.

Test Plan:
- Mount img_size=1048576 -> mounted=1, nsectors=2048. Then req_rd lba=5 -> sd_lba=5, sd_rd=1 next cycle. HPS acks and writes word k=k*0x0101 for k=0..255, then drops ack -> done 1 cycle later with err=0; core read of byte 0x1FF returns 0xFF.
- Core writes bytes 0..511 = addr[7:0], then req_wr lba=2047 -> sd_wr=1. During ack, sd_buff_addr=0x10 gives sd_buff_din=0x2120 one cycle later. Ack fall -> done with err=0.
- req_rd lba=2048 with nsectors=2048 -> no sd_rd, done next cycle with err=1. Same result for any request while unmounted, or req_wr with wprot=1.
- TIMEOUT=100, req_rd with no sd_ack -> sd_rd drops and done/err=1 exactly 100 cycles after entering REQ.
- req_rd and req_wr in the same cycle -> only sd_rd asserted. A second req_rd while busy is ignored, with exactly one done. Core buf_we during XFER leaves the buffer unchanged.
- reset_n low mid-XFER -> sd_rd/sd_wr/busy/done/err/mounted all 0 immediately, without waiting for a clock. After release, state is IDLE and a fresh mount plus read succeeds. img_mounted pulse during REQ -> done with err=1.
